ones_count_seq: RTL and testbench

//   Sequencer for the combinational ones-counter datapath. Accepts a burst of
//   1..MAX_WORDS words over a valid/ready stream, feeds each word through one

---
 rtl/ones_count_seq.sv | 142 ++++++++++++++
 tb/tb_ones_count_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ones_count_seq.sv
// Burst sequencer around a combinational ones-counter: accepts 1..MAX_WORDS words
// over valid/ready, accumulates the total set-bit count and returns it over valid/ready.
module ones_count_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_WORDS  = 8
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start,
    input  logic [$clog2(MAX_WORDS):0]                 num_words,
    input  logic                                       abort,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [DATA_WIDTH-1:0]                      din,
    output logic                                       busy,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [$clog2(DATA_WIDTH*MAX_WORDS):0]      total,
    output logic [$clog2(MAX_WORDS):0]                 words_done
);

    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam int NW = $clog2(MAX_WORDS) + 1;
    localparam int TW = $clog2(DATA_WIDTH * MAX_WORDS) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [NW-1:0]   len;
    logic [NW-1:0]   len_in;
    logic [TW-1:0]   acc;
    logic [TW-1:0]   acc_sum;
    logic            beat;
    logic            last_beat;

    // Ones-counter datapath: a plain adder chain over the word's bits.
    function automatic logic [CW-1:0] popcount(input logic [DATA_WIDTH-1:0] w);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            c = c + CW'(w[i]);
        end
        return c;
    endfunction

    function automatic logic [NW-1:0] sat_len(input logic [NW-1:0] n);
        return (n > NW'(MAX_WORDS)) ? NW'(MAX_WORDS) : n;
    endfunction

    assign len_in    = sat_len(num_words);
    assign beat      = in_valid & in_ready;
    assign last_beat = ((words_done + NW'(1)) == len);
    assign acc_sum   = acc + TW'(popcount(din));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Abort wins over a beat in the same cycle; start/abort are ignored outside their states.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (len_in == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (beat && last_beat) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        case (state)
            RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            DONE: busy = 1'b1;
            default: ;
        endcase
    end

    // Registered outputs; total and words_done stay frozen while the result waits in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len        <= '0;
            acc        <= '0;
            total      <= '0;
            words_done <= '0;
            out_valid  <= 1'b0;
        end else begin
            out_valid <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        len        <= len_in;
                        acc        <= '0;
                        total      <= '0;
                        words_done <= '0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        acc        <= '0;
                        words_done <= '0;
                    end else if (beat) begin
                        acc        <= acc_sum;
                        words_done <= words_done + NW'(1);
                        if (last_beat) begin
                            total <= acc_sum;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ones_count_seq.sv
// Scoreboard bench for ones_count_seq: bursts push their expected total/word count,
// results are popped and compared when out_valid appears.
module tb_ones_count_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  num_words;
    logic        abort;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] din;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  total;
    logic [3:0]  words_done;

    typedef struct {
        logic [7:0] tot;
        logic [3:0] wd;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] words[$];
    int          n_cmp;
    int          n_bad;
    logic        ready_ok;

    ones_count_seq #(.DATA_WIDTH(16), .MAX_WORDS(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_words  (num_words),
        .abort      (abort),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .din        (din),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .total      (total),
        .words_done (words_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge in IDLE; drives start, then the saturated number of beats
    // from 'words' with 'gap' idle cycles before each beat. Ends at a negedge.
    task automatic send_burst(input int n, input int gap);
        int   len;
        int   sum;
        exp_t e;
        len = (n > 8) ? 8 : n;
        sum = 0;
        for (int i = 0; i < len; i++) sum += $countones(words[i]);
        e.tot = 8'(sum);
        e.wd  = 4'(len);
        sb.push_back(e);
        ready_ok  = 1'b1;
        start     = 1'b1;
        num_words = 4'(n);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < len; i++) begin
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            if (in_ready !== 1'b1) ready_ok = 1'b0;
            in_valid = 1'b1;
            din      = words[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input int max_cyc, output logic ok, output int cyc);
        ok  = 1'b0;
        cyc = 0;
        while (cyc <= max_cyc) begin
            if (out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if ({in_ready, busy, out_valid} !== 3'b000) begin n_bad++;
            $display("FAIL reset_flags got=%b want=000", {in_ready, busy, out_valid}); end
        n_cmp++; if (total !== 8'd0) begin n_bad++;
            $display("FAIL reset_total got=%0d want=0", total); end
        n_cmp++; if (words_done !== 4'd0) begin n_bad++;
            $display("FAIL reset_words_done got=%0d want=0", words_done); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic ok;
        int   cyc;
        exp_t e;
        words = '{16'hFFFF, 16'h0001, 16'h00F0};
        send_burst(3, 0);
        wait_result(20, ok, cyc);
        e = sb.pop_front();
        n_cmp++; if (ok !== 1'b1 || cyc != 0) begin n_bad++;
            $display("FAIL basic_latency got ok=%b wait=%0d want ok=1 wait=0", ok, cyc); end
        n_cmp++; if (ready_ok !== 1'b1) begin n_bad++;
            $display("FAIL basic_in_ready_run got=%b want=1", ready_ok); end
        n_cmp++; if (total !== e.tot) begin n_bad++;
            $display("FAIL basic_total got=%0d want=%0d", total, e.tot); end
        n_cmp++; if (words_done !== e.wd) begin n_bad++;
            $display("FAIL basic_words_done got=%0d want=%0d", words_done, e.wd); end
        accept();
        n_cmp++; if ({out_valid, busy} !== 2'b00) begin n_bad++;
            $display("FAIL basic_after_accept got=%b want=00", {out_valid, busy}); end
    endtask

    task automatic test_gaps_stall();
        logic ok;
        int   cyc;
        exp_t e;
        words = '{16'hFFFF, 16'h0001, 16'h00F0};
        send_burst(3, 2);
        wait_result(20, ok, cyc);
        e = sb.pop_front();
        n_cmp++; if (ok !== 1'b1) begin n_bad++;
            $display("FAIL stall_timeout got=%b want=1", ok); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if ({out_valid, in_ready, busy} !== 3'b101) begin n_bad++;
                $display("FAIL stall_flags cyc=%0d got=%b want=101", i, {out_valid, in_ready, busy}); end
            n_cmp++; if (total !== e.tot || words_done !== e.wd) begin n_bad++;
                $display("FAIL stall_hold cyc=%0d got=%0d/%0d want=%0d/%0d",
                         i, total, words_done, e.tot, e.wd); end
            start = 1'b1;
            abort = 1'b1;
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
        end
        accept();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++;
            $display("FAIL stall_release got=%b want=0", out_valid); end
    endtask

    task automatic test_lengths(input int n, input logic [15:0] fill, input string name);
        logic ok;
        int   cyc;
        exp_t e;
        words = {};
        for (int i = 0; i < 12; i++)
            words.push_back((fill === 16'hxxxx) ? 16'($urandom) : fill);
        send_burst(n, 0);
        wait_result(20, ok, cyc);
        e = sb.pop_front();
        n_cmp++; if (ok !== 1'b1 || cyc != 0) begin n_bad++;
            $display("FAIL %s_latency got ok=%b wait=%0d want ok=1 wait=0", name, ok, cyc); end
        n_cmp++; if (total !== e.tot) begin n_bad++;
            $display("FAIL %s_total got=%0d want=%0d", name, total, e.tot); end
        n_cmp++; if (words_done !== e.wd || in_ready !== 1'b0) begin n_bad++;
            $display("FAIL %s_words_done got=%0d rdy=%b want=%0d rdy=0", name, words_done, in_ready, e.wd); end
        accept();
    endtask

    task automatic test_abort();
        logic ok;
        int   cyc;
        exp_t e;
        start     = 1'b1;
        num_words = 4'd4;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        din      = 16'hFFFF;
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        n_cmp++; if ({busy, in_ready, out_valid} !== 3'b000) begin n_bad++;
            $display("FAIL abort_idle got=%b want=000", {busy, in_ready, out_valid}); end
        n_cmp++; if (words_done !== 4'd0) begin n_bad++;
            $display("FAIL abort_words_done got=%0d want=0", words_done); end
        wait_result(4, ok, cyc);
        n_cmp++; if (ok !== 1'b0) begin n_bad++;
            $display("FAIL abort_no_out_valid got=%b want=0", ok); end
        words = '{16'h8001};
        send_burst(1, 0);
        wait_result(20, ok, cyc);
        e = sb.pop_front();
        n_cmp++; if (ok !== 1'b1 || total !== e.tot || words_done !== e.wd) begin n_bad++;
            $display("FAIL abort_next_burst got ok=%b total=%0d wd=%0d want ok=1 total=%0d wd=%0d",
                     ok, total, words_done, e.tot, e.wd); end
        accept();
    endtask

    task automatic test_async_reset();
        logic ok;
        int   cyc;
        exp_t e;
        start     = 1'b1;
        num_words = 4'd3;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        din      = 16'hFFFF;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_cmp++; if ({busy, in_ready, out_valid} !== 3'b000) begin n_bad++;
            $display("FAIL areset_flags got=%b want=000", {busy, in_ready, out_valid}); end
        n_cmp++; if (total !== 8'd0 || words_done !== 4'd0) begin n_bad++;
            $display("FAIL areset_data got=%0d/%0d want=0/0", total, words_done); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        words = '{16'hAAAA};
        send_burst(1, 0);
        wait_result(20, ok, cyc);
        e = sb.pop_front();
        n_cmp++; if (ok !== 1'b1 || total !== e.tot || words_done !== e.wd) begin n_bad++;
            $display("FAIL areset_next_burst got ok=%b total=%0d wd=%0d want ok=1 total=%0d wd=%0d",
                     ok, total, words_done, e.tot, e.wd); end
        accept();
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        start     = 1'b0;
        num_words = '0;
        abort     = 1'b0;
        in_valid  = 1'b0;
        din       = '0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_gaps_stall();
        test_lengths(0, 16'hFFFF, "zero_len");
        test_lengths(12, 16'hxxxx, "saturate");
        test_lengths(8, 16'hFFFF, "all_ones");
        test_lengths(8, 16'h0000, "all_zeros");
        test_lengths(5, 16'hxxxx, "random5");
        test_abort();
        test_async_reset();
        n_cmp++; if (sb.size() != 0) begin n_bad++;
            $display("FAIL scoreboard_leftover got=%0d want=0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
